// File: rtl/video_mode_sched.sv
// ---------------------------------------------------------------------------
// video_mode_sched
//
// Video mode scheduler. Holds the CPU-visible video configuration registers
// and drives the window, offset and mode inputs of the raster generator.
//
// CPU writes land in shadow registers. They are copied to the active set in
// one step at the frame boundary (frame_start qualified by c3), so the raster
// never sees a half-updated mode. The Y scroll offset is the exception: it is
// written straight through to rstart, and y_offs_wr tells the raster to
// re-latch it at its next line start.
//
// Ports
//   clk, rst          video clock, synchronous active-high reset
//   c3                7 MHz phase strobe, one clk wide
//   frame_start       raster at last pixel of last line (level)
//   wr_strb/addr/data register write port (one-clk strobe, 3-bit select)
//   hpix_*/vpix_*     pixel window (table lookup on active rres)
//   *_ts              tile/sprite window, identical to the pixel window
//   go_offs           DRAM fetch lead (table lookup on active vmode)
//   x_offs            fine X offset
//   hint_beg/vint_beg line-interrupt column/line
//   rstart/y_offs_wr  Y scroll start row and its one-clk change strobe
//   vmode/nogfx/cfg_60hz active mode bits
//   cfg_pending       a shadow write is waiting for the next commit
// ---------------------------------------------------------------------------
module video_mode_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       c3,
  input  logic       frame_start,
  input  logic       wr_strb,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [8:0] hpix_beg,
  output logic [8:0] hpix_end,
  output logic [8:0] vpix_beg,
  output logic [8:0] vpix_end,
  output logic [8:0] hpix_beg_ts,
  output logic [8:0] hpix_end_ts,
  output logic [8:0] vpix_beg_ts,
  output logic [8:0] vpix_end_ts,
  output logic [4:0] go_offs,
  output logic [1:0] x_offs,
  output logic [7:0] hint_beg,
  output logic [8:0] vint_beg,
  output logic [8:0] rstart,
  output logic       y_offs_wr,
  output logic [1:0] vmode,
  output logic       nogfx,
  output logic       cfg_60hz,
  output logic       cfg_pending
);

  localparam logic [2:0] A_VCONFIG = 3'd0;
  localparam logic [2:0] A_XOFFS   = 3'd1;
  localparam logic [2:0] A_YOFFSL  = 3'd2;
  localparam logic [2:0] A_YOFFSH  = 3'd3;
  localparam logic [2:0] A_HSINT   = 3'd4;
  localparam logic [2:0] A_VSINTL  = 3'd5;
  localparam logic [2:0] A_VSINTH  = 3'd6;

  localparam logic [7:0] HSINT_RST = 8'd1;

  // Window table: {h_beg, h_end, v_beg, v_end} for each rres value.
  function automatic logic [35:0] win_tab(input logic [1:0] rres);
    logic [35:0] w;
    case (rres)
      2'd0:    w = {9'd140, 9'd396, 9'd80, 9'd272};
      2'd1:    w = {9'd108, 9'd428, 9'd76, 9'd276};
      2'd2:    w = {9'd108, 9'd428, 9'd56, 9'd296};
      default: w = {9'd88,  9'd448, 9'd32, 9'd320};
    endcase
    return w;
  endfunction

  // DRAM fetch lead per video mode.
  function automatic logic [4:0] go_tab(input logic [1:0] mode);
    logic [4:0] g;
    case (mode)
      2'd1:    g = 5'd6;
      2'd2:    g = 5'd10;
      default: g = 5'd18;
    endcase
    return g;
  endfunction

  // Shadow registers (CPU side)
  logic [1:0] rres_sh_q,  rres_sh_d;
  logic [1:0] vmode_sh_q, vmode_sh_d;
  logic       nogfx_sh_q, nogfx_sh_d;
  logic       hz60_sh_q,  hz60_sh_d;
  logic [1:0] xoffs_sh_q, xoffs_sh_d;
  logic [7:0] hsint_sh_q, hsint_sh_d;
  logic [8:0] vsint_sh_q, vsint_sh_d;

  // Active registers (raster side)
  logic [1:0] rres_act_q,  rres_act_d;
  logic [1:0] vmode_act_q, vmode_act_d;
  logic       nogfx_act_q, nogfx_act_d;
  logic       hz60_act_q,  hz60_act_d;
  logic [1:0] xoffs_act_q, xoffs_act_d;
  logic [7:0] hsint_act_q, hsint_act_d;
  logic [8:0] vsint_act_q, vsint_act_d;

  logic       pending_q,   pending_d;
  logic [8:0] rstart_q,    rstart_d;
  logic       y_offs_wr_q, y_offs_wr_d;

  // Table-derived outputs
  logic [8:0] hbeg_p1_q, hbeg_p1_d;
  logic [8:0] hend_p1_q, hend_p1_d;
  logic [8:0] vbeg_p1_q, vbeg_p1_d;
  logic [8:0] vend_p1_q, vend_p1_d;
  logic [4:0] go_p1_q,   go_p1_d;

  logic commit;
  logic wr_shadowed;

  always_comb begin
    commit      = frame_start && c3;
    wr_shadowed = wr_strb && ((wr_addr == A_VCONFIG) || (wr_addr == A_XOFFS) ||
                              (wr_addr == A_HSINT)   || (wr_addr == A_VSINTL) ||
                              (wr_addr == A_VSINTH));

    rres_sh_d   = rres_sh_q;
    vmode_sh_d  = vmode_sh_q;
    nogfx_sh_d  = nogfx_sh_q;
    hz60_sh_d   = hz60_sh_q;
    xoffs_sh_d  = xoffs_sh_q;
    hsint_sh_d  = hsint_sh_q;
    vsint_sh_d  = vsint_sh_q;

    rres_act_d  = rres_act_q;
    vmode_act_d = vmode_act_q;
    nogfx_act_d = nogfx_act_q;
    hz60_act_d  = hz60_act_q;
    xoffs_act_d = xoffs_act_q;
    hsint_act_d = hsint_act_q;
    vsint_act_d = vsint_act_q;

    pending_d   = pending_q;
    rstart_d    = rstart_q;
    y_offs_wr_d = 1'b0;

    // Commit reads the registered shadow, so a write in the same clk lands
    // in the shadow only and goes out with the following frame.
    if (commit) begin
      rres_act_d  = rres_sh_q;
      vmode_act_d = vmode_sh_q;
      nogfx_act_d = nogfx_sh_q;
      hz60_act_d  = hz60_sh_q;
      xoffs_act_d = xoffs_sh_q;
      hsint_act_d = hsint_sh_q;
      vsint_act_d = vsint_sh_q;
      pending_d   = 1'b0;
    end

    // A write after the commit term keeps pending set for the next frame.
    if (wr_shadowed) begin
      pending_d = 1'b1;
    end

    if (wr_strb) begin
      case (wr_addr)
        A_VCONFIG: begin
          rres_sh_d  = wr_data[7:6];
          nogfx_sh_d = wr_data[5];
          hz60_sh_d  = wr_data[4];
          vmode_sh_d = wr_data[1:0];
        end
        A_XOFFS:  xoffs_sh_d       = wr_data[1:0];
        A_YOFFSL: begin
          rstart_d[7:0] = wr_data;
          y_offs_wr_d   = 1'b1;
        end
        A_YOFFSH: begin
          rstart_d[8]   = wr_data[0];
          y_offs_wr_d   = 1'b1;
        end
        A_HSINT:  hsint_sh_d       = wr_data;
        A_VSINTL: vsint_sh_d[7:0]  = wr_data;
        A_VSINTH: vsint_sh_d[8]    = wr_data[0];
        default:  ;
      endcase
    end

    {hbeg_p1_d, hend_p1_d, vbeg_p1_d, vend_p1_d} = win_tab(rres_act_q);
    go_p1_d = go_tab(vmode_act_q);
  end

  // Stage p0: shadow, active, Y offset and pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rres_sh_q   <= 2'd0;
      vmode_sh_q  <= 2'd0;
      nogfx_sh_q  <= 1'b0;
      hz60_sh_q   <= 1'b0;
      xoffs_sh_q  <= 2'd0;
      hsint_sh_q  <= HSINT_RST;
      vsint_sh_q  <= 9'd0;
      rres_act_q  <= 2'd0;
      vmode_act_q <= 2'd0;
      nogfx_act_q <= 1'b0;
      hz60_act_q  <= 1'b0;
      xoffs_act_q <= 2'd0;
      hsint_act_q <= HSINT_RST;
      vsint_act_q <= 9'd0;
      pending_q   <= 1'b0;
      rstart_q    <= 9'd0;
      y_offs_wr_q <= 1'b0;
    end else begin
      rres_sh_q   <= rres_sh_d;
      vmode_sh_q  <= vmode_sh_d;
      nogfx_sh_q  <= nogfx_sh_d;
      hz60_sh_q   <= hz60_sh_d;
      xoffs_sh_q  <= xoffs_sh_d;
      hsint_sh_q  <= hsint_sh_d;
      vsint_sh_q  <= vsint_sh_d;
      rres_act_q  <= rres_act_d;
      vmode_act_q <= vmode_act_d;
      nogfx_act_q <= nogfx_act_d;
      hz60_act_q  <= hz60_act_d;
      xoffs_act_q <= xoffs_act_d;
      hsint_act_q <= hsint_act_d;
      vsint_act_q <= vsint_act_d;
      pending_q   <= pending_d;
      rstart_q    <= rstart_d;
      y_offs_wr_q <= y_offs_wr_d;
    end
  end

  // Stage p1: table lookups, one clk behind the active registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hbeg_p1_q <= 9'd140;
      hend_p1_q <= 9'd396;
      vbeg_p1_q <= 9'd80;
      vend_p1_q <= 9'd272;
      go_p1_q   <= 5'd18;
    end else begin
      hbeg_p1_q <= hbeg_p1_d;
      hend_p1_q <= hend_p1_d;
      vbeg_p1_q <= vbeg_p1_d;
      vend_p1_q <= vend_p1_d;
      go_p1_q   <= go_p1_d;
    end
  end

  assign hpix_beg    = hbeg_p1_q;
  assign hpix_end    = hend_p1_q;
  assign vpix_beg    = vbeg_p1_q;
  assign vpix_end    = vend_p1_q;
  assign hpix_beg_ts = hbeg_p1_q;
  assign hpix_end_ts = hend_p1_q;
  assign vpix_beg_ts = vbeg_p1_q;
  assign vpix_end_ts = vend_p1_q;
  assign go_offs     = go_p1_q;
  assign x_offs      = xoffs_act_q;
  assign hint_beg    = hsint_act_q;
  assign vint_beg    = vsint_act_q;
  assign rstart      = rstart_q;
  assign y_offs_wr   = y_offs_wr_q;
  assign vmode       = vmode_act_q;
  assign nogfx       = nogfx_act_q;
  assign cfg_60hz    = hz60_act_q;
  assign cfg_pending = pending_q;

endmodule
